// File: rtl/data_ram_responder.sv
`default_nettype none
// =============================================================================
// Module   : data_ram_responder
// Purpose  : CPU data-memory responder with byte-serial preload port, sticky
//            address-error flag and saturating access counters.
// Revision : 1.0 - initial release
// =============================================================================
module data_ram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [3:0]            sel,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    output logic                  addr_err,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASM    = 2'd1,
        ST_COMMIT = 2'd2
    } ld_state_t;

    logic [31:0]           r_mem [c_DEPTH];
    ld_state_t             r_state;
    ld_state_t             w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_asm;

    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_in_range;
    logic                  w_sel_ok;
    logic                  w_misaligned;
    logic                  w_cpu_rd;
    logic                  w_cpu_wr;
    logic                  w_wr_ok;
    logic                  w_commit;

    assign w_index    = addr[DEPTH_LOG2+1:2];
    assign w_in_range = (addr[31:DEPTH_LOG2+2] == '0);

    always_comb begin
        w_sel_ok = 1'b0;
        case (sel)
            4'b1111, 4'b1100, 4'b0011,
            4'b1000, 4'b0100, 4'b0010, 4'b0001: w_sel_ok = 1'b1;
            default:                            w_sel_ok = 1'b0;
        endcase
    end

    assign w_misaligned = ce && (((addr[1:0] != 2'b00) && (sel == 4'b1111)) || !w_sel_ok);
    assign w_cpu_rd     = ce && !we;
    assign w_cpu_wr     = ce && we;
    assign w_wr_ok      = w_cpu_wr && w_in_range && !w_misaligned;

    // Same-cycle read path: the memory stage consumes data as it drives addr.
    assign rdata = (w_cpu_rd && w_in_range && rst) ? r_mem[w_index] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ASM: begin
                ld_ready = 1'b1;
                if (ld_valid && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // CPU writes own the RAM port; the loader word waits.
                if (!w_cpu_wr) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_ASM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (ld_start) begin
            w_state_nxt = ST_ASM;
            w_commit    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_byte_cnt <= 2'd0;
            r_asm      <= 32'h0;
        end else if (ld_start) begin
            r_wptr     <= ld_addr;
            r_byte_cnt <= 2'd0;
        end else if (w_commit) begin
            r_wptr     <= r_wptr + 1'b1;
            r_byte_cnt <= 2'd0;
        end else if (ld_ready && ld_valid) begin
            r_asm      <= {r_asm[23:0], ld_byte};
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    // Commit and CPU write are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wptr] <= r_asm;
        end else if (w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    r_mem[w_index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (ce && (!w_in_range || w_misaligned)) begin
                addr_err <= 1'b1;
            end
            if (w_cpu_rd && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
            if (w_cpu_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
